// File: rtl/key_bank_if.sv
// Button bank port bundle: raw pins toward the conditioner, debounced levels
// and single-cycle event pulses back to the control logic.
interface key_bank_if #(
    parameter int N_KEYS = 4
);
    logic [N_KEYS-1:0] key_in;
    logic [N_KEYS-1:0] key_state;
    logic [N_KEYS-1:0] key_press;
    logic [N_KEYS-1:0] key_release;
    logic [N_KEYS-1:0] key_long;
    logic [N_KEYS-1:0] key_repeat;

    modport master (
        output key_in,
        input  key_state,
        input  key_press,
        input  key_release,
        input  key_long,
        input  key_repeat
    );

    modport slave (
        input  key_in,
        output key_state,
        output key_press,
        output key_release,
        output key_long,
        output key_repeat
    );
endinterface

// File: rtl/key_bank.sv
// Multi-channel push-button conditioner: per-key synchroniser, debouncer and
// hold-time classifier producing press/release/long/repeat pulses.
module key_bank #(
    parameter int N_KEYS        = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int SYNC_STAGES   = 2,
    parameter int DB_CYCLES     = 2_500_000,
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000
) (
    input  logic      clk,
    input  logic      rst,
    key_bank_if.slave kb
);

    localparam int DBW      = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
    localparam int HOLD_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW       = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    localparam logic [DBW-1:0] DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [HW-1:0]  LONG_LAST = (LONG_CYCLES > 0) ? HW'(LONG_CYCLES - 1) : '0;
    localparam logic [HW-1:0]  REP_LAST  = (REPEAT_CYCLES > 0) ? HW'(REPEAT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HELD    = 2'd1,
        ST_LONG    = 2'd2,
        ST_LATCHED = 2'd3
    } hold_state_t;

    function automatic logic [HW-1:0] sat_inc(input logic [HW-1:0] v);
        sat_inc = (&v) ? v : v + HW'(1);
    endfunction

    logic [N_KEYS-1:0]      key_norm_s;
    logic [N_KEYS-1:0]      press_s;
    logic [N_KEYS-1:0]      release_s;
    logic [DBW-1:0]         db_next_s [N_KEYS];

    logic [SYNC_STAGES-1:0] sync_r    [N_KEYS];
    logic [DBW-1:0]         db_cnt_r  [N_KEYS];
    logic [HW-1:0]          hold_cnt_r[N_KEYS];
    hold_state_t            state_r   [N_KEYS];

    logic [N_KEYS-1:0]      key_state_r;
    logic [N_KEYS-1:0]      key_press_r;
    logic [N_KEYS-1:0]      key_release_r;
    logic [N_KEYS-1:0]      key_long_r;
    logic [N_KEYS-1:0]      key_repeat_r;

    // Normalise pins so that 1 always means pressed inside the block.
    assign key_norm_s = (ACTIVE_LOW != 0) ? ~kb.key_in : kb.key_in;

    assign kb.key_state   = key_state_r;
    assign kb.key_press   = key_press_r;
    assign kb.key_release = key_release_r;
    assign kb.key_long    = key_long_r;
    assign kb.key_repeat  = key_repeat_r;

    // Debounce decision: a disagreement must persist DB_CYCLES edges to commit.
    always_comb begin
        for (int i = 0; i < N_KEYS; i++) begin
            press_s[i]   = 1'b0;
            release_s[i] = 1'b0;
            db_next_s[i] = '0;
            if (sync_r[i][SYNC_STAGES-1] == key_state_r[i]) begin
                db_next_s[i] = '0;
            end else if (db_cnt_r[i] == DB_LAST) begin
                press_s[i]   = sync_r[i][SYNC_STAGES-1];
                release_s[i] = ~sync_r[i][SYNC_STAGES-1];
                db_next_s[i] = '0;
            end else begin
                db_next_s[i] = db_cnt_r[i] + DBW'(1);
            end
        end
    end

    // Synchronisers, debounce counters, committed level and press/release pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_KEYS; i++) begin
                sync_r[i]   <= '0;
                db_cnt_r[i] <= '0;
            end
            key_state_r   <= '0;
            key_press_r   <= '0;
            key_release_r <= '0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                sync_r[i]   <= {sync_r[i][SYNC_STAGES-2:0], key_norm_s[i]};
                db_cnt_r[i] <= db_next_s[i];
            end
            key_state_r   <= (key_state_r | press_s) & ~release_s;
            key_press_r   <= press_s;
            key_release_r <= release_s;
        end
    end

    // Per-key hold classifier; a release commit wins over long/repeat on the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_KEYS; i++) begin
                state_r[i]    <= ST_IDLE;
                hold_cnt_r[i] <= '0;
            end
            key_long_r   <= '0;
            key_repeat_r <= '0;
        end else begin
            key_long_r   <= '0;
            key_repeat_r <= '0;
            for (int i = 0; i < N_KEYS; i++) begin
                if (release_s[i]) begin
                    state_r[i]    <= ST_IDLE;
                    hold_cnt_r[i] <= '0;
                end else begin
                    case (state_r[i])
                        ST_IDLE: begin
                            if (press_s[i]) begin
                                state_r[i]    <= ST_HELD;
                                hold_cnt_r[i] <= '0;
                            end
                        end
                        ST_HELD: begin
                            // With long-press disabled this state simply waits for release.
                            if (LONG_CYCLES != 0) begin
                                if (hold_cnt_r[i] == LONG_LAST) begin
                                    key_long_r[i] <= 1'b1;
                                    hold_cnt_r[i] <= '0;
                                    state_r[i]    <= (REPEAT_CYCLES != 0) ? ST_LONG : ST_LATCHED;
                                end else begin
                                    hold_cnt_r[i] <= sat_inc(hold_cnt_r[i]);
                                end
                            end
                        end
                        ST_LONG: begin
                            if (hold_cnt_r[i] == REP_LAST) begin
                                key_repeat_r[i] <= 1'b1;
                                hold_cnt_r[i]   <= '0;
                            end else begin
                                hold_cnt_r[i] <= sat_inc(hold_cnt_r[i]);
                            end
                        end
                        ST_LATCHED: begin
                            hold_cnt_r[i] <= hold_cnt_r[i];
                        end
                        default: begin
                            state_r[i]    <= ST_IDLE;
                            hold_cnt_r[i] <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_key_bank.sv
// Directed self-checking bench for key_bank with short debounce/hold timings.
module tb_key_bank;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    key_bank_if #(.N_KEYS(2)) kb();

    key_bank #(
        .N_KEYS(2), .ACTIVE_LOW(1), .SYNC_STAGES(2),
        .DB_CYCLES(4), .LONG_CYCLES(20), .REPEAT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .kb (kb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs n edges, recording event edges for channel idx; key_in changes after edge chg_at.
    task automatic observe(input int n, input int idx, input int chg_at, input logic [1:0] chg_val,
                           output int p, output int r, output int l,
                           output int np, output int nr, output int nl, output int nrep,
                           output int r1, output int r2, output int other);
        p = -1; r = -1; l = -1; np = 0; nr = 0; nl = 0; nrep = 0; r1 = -1; r2 = -1; other = 0;
        for (int e = 1; e <= n; e++) begin
            step();
            if (kb.key_press[idx])   begin np++; if (p < 0) p = e; end
            if (kb.key_release[idx]) begin nr++; if (r < 0) r = e; end
            if (kb.key_long[idx])    begin nl++; if (l < 0) l = e; end
            if (kb.key_repeat[idx]) begin
                nrep++;
                if (r1 < 0) r1 = e;
                else if (r2 < 0) r2 = e;
            end
            if ((kb.key_press[1-idx] | kb.key_release[1-idx] | kb.key_long[1-idx] |
                 kb.key_repeat[1-idx] | kb.key_state[1-idx]) !== 1'b0) other++;
            if (e == chg_at) kb.key_in = chg_val;
        end
    endtask

    task automatic test_reset();
        int p0, p1, r, rr, l, np, nr, nl, nrep, r1, r2, other;
        logic [9:0] outs;
        rst = 1'b1;
        kb.key_in = 2'b00;
        for (int c = 0; c < 3; c++) begin
            step();
            outs = {kb.key_state, kb.key_press, kb.key_release, kb.key_long, kb.key_repeat};
            checks++;
            if (outs !== 10'b0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got %b expected %b", c, outs, 10'b0);
            end
        end
        rst = 1'b0;
        p0 = -1; p1 = -1;
        for (int e = 1; e <= 12; e++) begin
            step();
            if (kb.key_press[0] && p0 < 0) p0 = e;
            if (kb.key_press[1] && p1 < 0) p1 = e;
        end
        checks++;
        if (p0 !== 6) begin errors++; $display("FAIL reset_press0_edge: got %0d expected %0d", p0, 6); end
        checks++;
        if (p1 !== 6) begin errors++; $display("FAIL reset_press1_edge: got %0d expected %0d", p1, 6); end
        checks++;
        if (kb.key_state !== 2'b11) begin
            errors++; $display("FAIL reset_state_pressed: got %b expected %b", kb.key_state, 2'b11);
        end
        kb.key_in = 2'b11;
        observe(12, 0, 0, 2'b11, p0, r, l, np, nr, nl, nrep, r1, r2, other);
        checks++;
        if (r !== 6) begin errors++; $display("FAIL reset_release0_edge: got %0d expected %0d", r, 6); end
        rr = r;
        checks++;
        if (kb.key_state !== 2'b00) begin
            errors++; $display("FAIL reset_state_released: got %b expected %b (rel edge %0d)", kb.key_state, 2'b00, rr);
        end
    endtask

    task automatic test_press_release();
        int p, r, l, np, nr, nl, nrep, r1, r2, other;
        kb.key_in = 2'b10;
        observe(12, 0, 0, 2'b10, p, r, l, np, nr, nl, nrep, r1, r2, other);
        checks++;
        if (p !== 6) begin errors++; $display("FAIL press_edge: got %0d expected %0d", p, 6); end
        checks++;
        if (np !== 1) begin errors++; $display("FAIL press_width: got %0d expected %0d", np, 1); end
        checks++;
        if (kb.key_state !== 2'b01) begin
            errors++; $display("FAIL press_state: got %b expected %b", kb.key_state, 2'b01);
        end
        kb.key_in = 2'b11;
        observe(12, 0, 0, 2'b11, p, r, l, np, nr, nl, nrep, r1, r2, other);
        checks++;
        if (r !== 6) begin errors++; $display("FAIL release_edge: got %0d expected %0d", r, 6); end
        checks++;
        if (nr !== 1) begin errors++; $display("FAIL release_width: got %0d expected %0d", nr, 1); end
        checks++;
        if (kb.key_state !== 2'b00) begin
            errors++; $display("FAIL release_state: got %b expected %b", kb.key_state, 2'b00);
        end
    endtask

    task automatic test_bounce();
        int p, r, l, np, nr, nl, nrep, r1, r2, other;
        int bounce_press;
        bounce_press = 0;
        for (int rep = 0; rep < 5; rep++) begin
            kb.key_in = 2'b10;
            for (int c = 0; c < 3; c++) begin
                step();
                if (kb.key_press[0] | kb.key_state[0]) bounce_press++;
            end
            kb.key_in = 2'b11;
            step();
            if (kb.key_press[0] | kb.key_state[0]) bounce_press++;
        end
        checks++;
        if (bounce_press !== 0) begin
            errors++; $display("FAIL bounce_no_press: got %0d expected %0d", bounce_press, 0);
        end
        kb.key_in = 2'b10;
        observe(12, 0, 0, 2'b10, p, r, l, np, nr, nl, nrep, r1, r2, other);
        checks++;
        if (p !== 6) begin errors++; $display("FAIL bounce_final_press: got %0d expected %0d", p, 6); end
        kb.key_in = 2'b11;
        observe(12, 0, 0, 2'b11, p, r, l, np, nr, nl, nrep, r1, r2, other);
        checks++;
        if (r !== 6) begin errors++; $display("FAIL bounce_release: got %0d expected %0d", r, 6); end
    endtask

    task automatic test_long_repeat();
        int p, r, l, np, nr, nl, nrep, r1, r2, other;
        kb.key_in = 2'b01;
        observe(70, 1, 43, 2'b11, p, r, l, np, nr, nl, nrep, r1, r2, other);
        checks++;
        if (p !== 6) begin errors++; $display("FAIL long_press_edge: got %0d expected %0d", p, 6); end
        checks++;
        if (l !== 26) begin errors++; $display("FAIL long_edge: got %0d expected %0d", l, 26); end
        checks++;
        if (nl !== 1) begin errors++; $display("FAIL long_count: got %0d expected %0d", nl, 1); end
        checks++;
        if (r1 !== 34) begin errors++; $display("FAIL repeat1_edge: got %0d expected %0d", r1, 34); end
        checks++;
        if (r2 !== 42) begin errors++; $display("FAIL repeat2_edge: got %0d expected %0d", r2, 42); end
        checks++;
        if (nrep !== 2) begin errors++; $display("FAIL repeat_count: got %0d expected %0d", nrep, 2); end
        checks++;
        if (r !== 49) begin errors++; $display("FAIL long_release_edge: got %0d expected %0d", r, 49); end
        checks++;
        if (other !== 0) begin errors++; $display("FAIL long_key0_quiet: got %0d expected %0d", other, 0); end
    endtask

    task automatic test_collision();
        int p, r, l, np, nr, nl, nrep, r1, r2, other;
        kb.key_in = 2'b10;
        observe(40, 0, 20, 2'b11, p, r, l, np, nr, nl, nrep, r1, r2, other);
        checks++;
        if (p !== 6) begin errors++; $display("FAIL coll_press_edge: got %0d expected %0d", p, 6); end
        checks++;
        if (r !== 26) begin errors++; $display("FAIL coll_release_edge: got %0d expected %0d", r, 26); end
        checks++;
        if (nl !== 0) begin errors++; $display("FAIL coll_long_suppressed: got %0d expected %0d", nl, 0); end
        checks++;
        if (nrep !== 0) begin errors++; $display("FAIL coll_no_repeat: got %0d expected %0d", nrep, 0); end
    endtask

    task automatic test_reset_mid_hold();
        int p, r, l, np, nr, nl, nrep, r1, r2, other;
        logic [9:0] outs;
        kb.key_in = 2'b10;
        observe(36, 0, 0, 2'b10, p, r, l, np, nr, nl, nrep, r1, r2, other);
        checks++;
        if (r1 !== 34) begin errors++; $display("FAIL midhold_repeat_before: got %0d expected %0d", r1, 34); end
        rst = 1'b1;
        step();
        outs = {kb.key_state, kb.key_press, kb.key_release, kb.key_long, kb.key_repeat};
        checks++;
        if (outs !== 10'b0) begin
            errors++; $display("FAIL midhold_reset_outputs: got %b expected %b", outs, 10'b0);
        end
        step();
        rst = 1'b0;
        observe(24, 0, 0, 2'b10, p, r, l, np, nr, nl, nrep, r1, r2, other);
        checks++;
        if (p !== 6) begin errors++; $display("FAIL midhold_repress_edge: got %0d expected %0d", p, 6); end
        checks++;
        if (nrep !== 0) begin errors++; $display("FAIL midhold_repeats_stopped: got %0d expected %0d", nrep, 0); end
        checks++;
        if (nl !== 0) begin errors++; $display("FAIL midhold_no_early_long: got %0d expected %0d", nl, 0); end
        kb.key_in = 2'b11;
        observe(12, 0, 0, 2'b11, p, r, l, np, nr, nl, nrep, r1, r2, other);
        checks++;
        if (r !== 6) begin errors++; $display("FAIL midhold_release_edge: got %0d expected %0d", r, 6); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        kb.key_in = 2'b00;
        test_reset();
        test_press_release();
        test_bounce();
        test_long_repeat();
        test_collision();
        test_reset_mid_hold();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_bank.md
# key_bank

Multi-channel push-button conditioner: synchronises, debounces and classifies N_KEYS raw button inputs. It is a parametrised successor of the single-key 50 ms debouncer. Beyond a stable level per key, it emits press, release, long-press and auto-repeat event pulses. It sits between the board button pins and the control logic, which consumes single-cycle events instead of polling levels.

## Interface
Parameters:
- N_KEYS, 4: number of independent channels.
- ACTIVE_LOW, 1: 1 means a pin reads 0 when pressed; all outputs are active-high "pressed/event" regardless.
- SYNC_STAGES, 2: flip-flops per input synchroniser; must be ≥ 2.
- DB_CYCLES, 2_500_000: consecutive cycles of disagreement needed to commit a new level (50 ms at 50 MHz); must be ≥ 1.
- LONG_CYCLES, 50_000_000: hold time after press before key_long fires; 0 disables long-press and repeat.
- REPEAT_CYCLES, 10_000_000: auto-repeat period after key_long; 0 disables repeat.

Ports:
- clk  in  1  system clock, 50 MHz nominal.
- rst  in  1  synchronous, active-high reset.
- key_in  in  N_KEYS  raw asynchronous button pins.
- key_state  out  N_KEYS  debounced level, 1 = pressed.
- key_press  out  N_KEYS  1-cycle pulse on committed press.
- key_release  out  N_KEYS  1-cycle pulse on committed release.
- key_long  out  N_KEYS  1-cycle pulse when a press has been held LONG_CYCLES.
- key_repeat  out  N_KEYS  1-cycle pulse every REPEAT_CYCLES after key_long while held.

## Operation
- All channels are identical and fully independent. There is no shared counter.
- Synchroniser: a SYNC_STAGES-deep shift register per key. The input is normalised (inverted if ACTIVE_LOW) before the first stage. The last stage output is s.
- Debounce counter db_cnt, width $clog2(DB_CYCLES+1). The action on every edge is the first matching rule:
  - s == key_state: db_cnt ← 0.
  - db_cnt == DB_CYCLES−1: key_state ← s; db_cnt ← 0; pulse key_press (if s=1) or key_release (if s=0).
  - otherwise: db_cnt ← db_cnt+1.
- Any bounce back to the committed level restarts the count. A glitch shorter than DB_CYCLES cycles never changes key_state.
- Hold counter hold_cnt saturates and is wide enough for max(LONG_CYCLES, REPEAT_CYCLES). Per-channel FSM:
  - IDLE (key_state=0) → HELD on a press commit; hold_cnt ← 0.
  - HELD: hold_cnt increments each cycle. When hold_cnt == LONG_CYCLES−1, pulse key_long, hold_cnt ← 0, go to LONG if REPEAT_CYCLES≠0, else to LATCHED.
  - LONG: hold_cnt increments. When hold_cnt == REPEAT_CYCLES−1, pulse key_repeat and set hold_cnt ← 0.
  - LATCHED: idle until release.
  - Any state → IDLE on a release commit.
- With LONG_CYCLES=0, HELD never fires and acts as LATCHED.
- Simultaneous events: on an edge that commits a release, key_long and key_repeat are suppressed. release has priority.
- All outputs are registered. Pulses are high for exactly one cycle.

## Timing
- Reset (rst=1 at an edge):
  - synchronisers are loaded with the released level;
  - db_cnt and hold_cnt are cleared to 0;
  - FSM goes to IDLE;
  - key_state, key_press, key_release, key_long and key_repeat all become 0 after that edge.
- Reset in the middle of a press discards it. After reset, a key that is still pressed produces a fresh key_press after the full latency.
- Commit latency: key_in settles before edge 1, and key_state plus the press/release pulse go high after edge SYNC_STAGES+DB_CYCLES. key_state and the event pulse change on the same edge.
- key_long follows key_press by exactly LONG_CYCLES edges.
- The first key_repeat follows key_long by REPEAT_CYCLES edges, and later repeats keep the same spacing.
- A key held across reset deassertion behaves as a new press.

## Test plan
All scenarios use N_KEYS=2, ACTIVE_LOW=1, SYNC_STAGES=2, DB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=8.

- **Reset values:** hold rst for 3 cycles with key_in=2'b00 (pressed) → all outputs 0 during reset. key0 and key1 key_press both fire 6 edges after rst falls.
- **Clean press and release on key0:** key_in[0] goes 1→0 → key_press[0] is a 1-cycle pulse and key_state[0]=1 after edge 6. Then 0→1 → key_release[0] after edge 6 and key_state[0]=0.
- **Bounce rejection:** key_in[0] is low for 3 cycles, high for 1, then repeats 5 times, then stays low → no press during the bounces. key_press[0] fires 6 edges after the final fall.
- **Long press and repeat:** hold key1 → key_long[1] fires 20 cycles after key_press[1], then key_repeat[1] at +8 and +16. Releasing gives key_release[1] and no further repeats. key0 outputs stay 0 throughout.
- **Release/long collision:** arrange the release commit on the same edge where hold_cnt reaches 19 → key_release pulses and key_long stays 0.
- **Reset mid-hold:** assert rst while key0 is in LONG → repeats stop and key_state=0. With the key still held, key_press[0] refires 6 edges after rst deasserts.
